// File: rtl/debug_link_pkg.sv
// Shared constants and frame-FSM state type for the CPU debug link.
package debug_link_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_BYTES       = 9;
  localparam int unsigned BITS_PER_BYTE     = 10;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } frame_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: owns baud counter, bit counter, shift register and the tx line.
module uart_tx_byte
  import debug_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int unsigned    BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(BITS_PER_BYTE - 1);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [8:0]        shreg;

  // done marks the last cycle of the stop bit, so a following byte can be
  // loaded on that same edge with no idle gap between bytes.
  assign done  = active && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_LAST);
  assign ready = !active || done;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (load && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active  <= 1'b0;
          bit_cnt <= '0;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots the seven debug ports on request and sends sync, port1..7, checksum as 8N1 UART.
module debug_uart_tx
  import debug_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] port1,
  input  logic [7:0] port2,
  input  logic [7:0] port3,
  input  logic [7:0] port4,
  input  logic [7:0] port5,
  input  logic [7:0] port6,
  input  logic [7:0] port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  frame_state_t state;
  logic [3:0]   byte_idx;
  logic [3:0]   next_idx;
  logic [7:0]   snap [7];
  logic [7:0]   csum;
  logic [7:0]   port_sum;
  logic [7:0]   load_data;
  logic         accept;
  logic         byte_load;
  logic         byte_ready;
  logic         byte_done;

  assign accept   = start && !busy;
  assign port_sum = port1 + port2 + port3 + port4 + port5 + port6 + port7;
  assign next_idx = byte_idx + 4'd1;
  assign byte_load = byte_ready &&
                     (accept || ((state == SEND) && byte_done && (byte_idx != LAST_IDX)));

  // Byte 0 is loaded on the accept edge itself, before the snapshot registers settle.
  always_comb begin
    load_data = SYNC_BYTE;
    if (!accept) begin
      unique case (next_idx)
        4'd1:    load_data = snap[0];
        4'd2:    load_data = snap[1];
        4'd3:    load_data = snap[2];
        4'd4:    load_data = snap[3];
        4'd5:    load_data = snap[4];
        4'd6:    load_data = snap[5];
        4'd7:    load_data = snap[6];
        4'd8:    load_data = csum;
        default: load_data = SYNC_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      byte_idx   <= '0;
      csum       <= '0;
      snap       <= '{default: '0};
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        state    <= SEND;
        busy     <= 1'b1;
        overrun  <= 1'b0;
        byte_idx <= '0;
        csum     <= port_sum;
        snap     <= '{port1, port2, port3, port4, port5, port6, port7};
      end else begin
        if (start) overrun <= 1'b1;
        unique case (state)
          SEND: begin
            if (byte_done) begin
              if (byte_idx == LAST_IDX) begin
                state      <= DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                byte_idx <= next_idx;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .nreset(nreset),
    .load  (byte_load),
    .data  (load_data),
    .ready (byte_ready),
    .done  (byte_done),
    .tx    (tx)
  );

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx at 4 clocks per bit: frame vectors plus reset/overrun/back-to-back cases.
module tb_debug_uart_tx;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] port1 = '0, port2 = '0, port3 = '0, port4 = '0;
  logic [7:0] port5 = '0, port6 = '0, port7 = '0;
  logic       tx, busy, frame_done, overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debug_uart_tx #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .port1     (port1),
    .port2     (port2),
    .port3     (port3),
    .port4     (port4),
    .port5     (port5),
    .port6     (port6),
    .port7     (port7),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  // UART receiver model: samples mid-bit on negedges, 4 cycles per bit
  logic [7:0] rx_q[$];
  int         framing_err = 0;
  bit         in_byte = 1'b0;
  int         bcnt = 0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    if (!nreset) begin
      in_byte = 1'b0;
    end else if (!in_byte) begin
      if (tx === 1'b0) begin
        in_byte = 1'b1;
        bcnt = 0;
      end
    end else begin
      bcnt++;
      if ((bcnt % 4) == 2 && (bcnt / 4) >= 1 && (bcnt / 4) <= 8) sh[bcnt/4 - 1] = tx;
      if (bcnt == 38 && tx !== 1'b1) framing_err++;
      if (bcnt == 39) begin
        in_byte = 1'b0;
        rx_q.push_back(sh);
      end
    end
  end

  typedef struct {
    logic [55:0] ports;   // port1 in the top byte
    logic [7:0]  csum;
    bit          change_mid;
    bit          ovr_pulse;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ports(input logic [55:0] p);
    {port1, port2, port3, port4, port5, port6, port7} = p;
  endtask

  task automatic check_bytes(input logic [55:0] p, input logic [7:0] cs, input int base, input string tag);
    logic [7:0] exp, got;
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      exp = 8'hA5;
      else if (i == 8) exp = cs;
      else             exp = p[63 - 8*i -: 8];
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp});
    end
  endtask

  task automatic run_vector(input int v);
    int k, done_k;
    rx_q.delete();
    framing_err = 0;
    @(negedge clk);
    set_ports(tbl[v].ports);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_start_bit", v), {31'd0, tx}, 32'd0);
    check($sformatf("v%0d_busy_on", v), {31'd0, busy}, 32'd1);
    check($sformatf("v%0d_overrun_clr", v), {31'd0, overrun}, 32'd0);
    k = 0;
    done_k = -1;
    while (k < 400 && done_k < 0) begin
      @(negedge clk);
      k++;
      if (k == 50 && tbl[v].change_mid) set_ports('0);
      if (k == 100 && tbl[v].ovr_pulse) start = 1'b1;
      if (k == 101) start = 1'b0;
      if (frame_done === 1'b1) done_k = k;
    end
    check($sformatf("v%0d_frame_len", v), done_k, 32'd360);
    check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_tx_idle", v), {31'd0, tx}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_done_1cyc", v), {31'd0, frame_done}, 32'd0);
    check($sformatf("v%0d_rx_count", v), rx_q.size(), 32'd9);
    check_bytes(tbl[v].ports, tbl[v].csum, 0, $sformatf("v%0d", v));
    check($sformatf("v%0d_overrun", v), {31'd0, overrun}, {31'd0, tbl[v].ovr_pulse});
    check($sformatf("v%0d_framing", v), framing_err, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stop_hi, bad;
    tbl[0] = '{ports: 56'h01020304050607, csum: 8'h1C, change_mid: 1'b0, ovr_pulse: 1'b0};
    tbl[1] = '{ports: 56'hFFFFFFFFFFFFFF, csum: 8'hF9, change_mid: 1'b1, ovr_pulse: 1'b0};
    tbl[2] = '{ports: 56'h01020304050607, csum: 8'h1C, change_mid: 1'b0, ovr_pulse: 1'b1};
    tbl[3] = '{ports: 56'h123456789ABCDE, csum: 8'h48, change_mid: 1'b0, ovr_pulse: 1'b0};
    tbl[4] = '{ports: 56'h80402010080402, csum: 8'hFE, change_mid: 1'b0, ovr_pulse: 1'b0};
    tbl[5] = '{ports: 56'hAA55AA55AA55AA, csum: 8'hA7, change_mid: 1'b0, ovr_pulse: 1'b0};

    // Reset
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    for (int v = 0; v < 6; v++) run_vector(v);

    // Start held high: frames run back-to-back
    rx_q.delete();
    framing_err = 0;
    @(negedge clk);
    set_ports(56'h01020304050607);
    start = 1'b1;
    @(negedge clk);
    stop_hi = 0;
    for (int k = 1; k <= 724; k++) begin
      @(negedge clk);
      if (k >= 352 && k <= 360 && tx === 1'b1 && busy === 1'b1) stop_hi++;
      if (k == 360) begin
        check("b2b_done1", {31'd0, frame_done}, 32'd1);
        check("b2b_busy_low", {31'd0, busy}, 32'd0);
        check("b2b_tx_done", {31'd0, tx}, 32'd1);
      end
      if (k == 361) begin
        check("b2b_restart_tx", {31'd0, tx}, 32'd0);
        check("b2b_restart_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_pulse", {31'd0, frame_done}, 32'd0);
      end
      if (k == 700) start = 1'b0;
      if (k == 721) check("b2b_done2", {31'd0, frame_done}, 32'd1);
      if (k == 722) check("b2b_idle", {31'd0, tx & ~busy}, 32'd1);
    end
    check("b2b_stop_len", stop_hi, 32'd4);
    check("b2b_rx_count", rx_q.size(), 32'd18);
    check_bytes(56'h01020304050607, 8'h1C, 9, "b2b");
    check("b2b_framing", framing_err, 32'd0);

    // Reset mid data bit
    rx_q.delete();
    @(negedge clk);
    set_ports(56'h01020304050607);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (57) @(negedge clk);
    check("mid_tx_before", {31'd0, tx}, 32'd0);
    nreset = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("mid_rst_quiet", bad, 32'd0);
    check("mid_rst_rx", rx_q.size(), 32'd1);

    run_vector(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
